// File: rtl/if_stage_pipeline_reg.sv
// Instruction-fetch stage for the 5-stage MIPS pipeline: PC register, IF/ID pipeline
// register, and saturating stall/flush event counters for performance debug.
module if_stage_pipeline_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic [31:0]          BranchTarget,
    input  logic [31:0]          Instruction_i,
    output logic [31:0]          PC_o,
    output logic [31:0]          IF_ID_Instruction,
    output logic [31:0]          IF_ID_PCPlus4,
    output logic                 IF_ID_Valid,
    output logic [4:0]           IF_ID_RegisterRs,
    output logic [4:0]           IF_ID_RegisterRt,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [31:0] pcPlus4;
    assign pcPlus4 = PC_o + 32'd4;

    // Reset first, then Flush beats Stall, then normal advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC_o              <= RESET_PC;
            IF_ID_Instruction <= 32'd0;
            IF_ID_PCPlus4     <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            StallCount        <= '0;
            FlushCount        <= '0;
        end else if (Flush) begin
            PC_o              <= {BranchTarget[31:2], 2'b00};
            IF_ID_Instruction <= 32'd0;
            IF_ID_PCPlus4     <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            if (FlushCount != CntMax) begin
                FlushCount <= FlushCount + CNT_WIDTH'(1);
            end
        end else if (Stall) begin
            if (StallCount != CntMax) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
        end else begin
            PC_o              <= pcPlus4;
            IF_ID_Instruction <= Instruction_i;
            IF_ID_PCPlus4     <= pcPlus4;
            IF_ID_Valid       <= 1'b1;
        end
    end

    // A bubble reads as $0/$0; the hazard unit qualifies matches with IF_ID_Valid.
    assign IF_ID_RegisterRs = IF_ID_Instruction[25:21];
    assign IF_ID_RegisterRt = IF_ID_Instruction[20:16];

endmodule

// File: doc/if_stage_pipeline_reg.md
Name: if_stage_pipeline_reg

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC, drives the instruction-memory address, and captures the fetched instruction and PC+4 into IF/ID.
- Consumes Stall and Flush from the hazard detection unit. Stall freezes the PC and IF/ID. Flush redirects the PC to the resolved branch target and bubbles IF/ID.
- Feeds IF/ID Rs/Rt back to the hazard detection unit. Keeps saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (start of the text segment).
CNT_WIDTH, 16, width of the stall and flush event counters.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
Stall  input  1  load-use stall request from hazard detection unit
Flush  input  1  branch-taken flush request from hazard detection unit
BranchTarget  input  32  redirect address, valid when Flush=1
Instruction_i  input  32  instruction-memory read data for the current PC (combinational read)
PC_o  output  32  current PC, instruction-memory address
IF_ID_Instruction  output  32  registered instruction for ID
IF_ID_PCPlus4  output  32  registered PC+4 for ID
IF_ID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
IF_ID_RegisterRs  output  5  IF_ID_Instruction[25:21], combinational from the register
IF_ID_RegisterRt  output  5  IF_ID_Instruction[20:16], combinational from the register
StallCount  output  CNT_WIDTH  number of stalled cycles, saturating
FlushCount  output  CNT_WIDTH  number of flush cycles, saturating

Behaviour:
- Reset is sampled only at the rising clk edge while reset=0. Asynchronous assertion has no effect until the edge.
- Reset values: PC_o=RESET_PC; IF_ID_Instruction=0 (sll $0,$0,0 nop); IF_ID_PCPlus4=0; IF_ID_Valid=0; StallCount=0; FlushCount=0.
- Reset has priority over everything. A reset mid-stall or mid-flush discards the pending action. The first fetch after reset release is from RESET_PC.
- Per-edge priority when reset=1: Flush > Stall > normal advance.
- Normal (Flush=0, Stall=0):
  - PC <= PC+4.
  - IF_ID_Instruction <= Instruction_i.
  - IF_ID_PCPlus4 <= PC+4.
  - IF_ID_Valid <= 1.
- Stall (Stall=1, Flush=0):
  - PC and all IF/ID registers hold.
  - StallCount increments unless it is all-ones.
  - Multi-cycle stalls hold indefinitely. There is no timeout.
- Flush (Flush=1, regardless of Stall):
  - PC <= {BranchTarget[31:2],2'b00}.
  - IF_ID_Instruction <= 0; IF_ID_PCPlus4 <= 0; IF_ID_Valid <= 0.
  - FlushCount increments unless it is all-ones. StallCount does not change.
- Latency:
  - An instruction fetched at PC in cycle N appears on the IF/ID outputs after the edge ending cycle N.
  - A redirect takes effect on PC_o one edge after Flush is sampled.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. No exception is raised.
- BranchTarget bits [1:0] are ignored; the PC is always word aligned.
- Counters are CNT_WIDTH unsigned and hold at 2^CNT_WIDTH-1. They are cleared only by reset.
- IF_ID_RegisterRs/Rt are pure slices of the IF/ID register. On a bubble they read 0, so an EX load to $0 matches a bubble. Suppressing that match is the hazard unit's job, gated by IF_ID_Valid.
- There are no combinational paths from Stall/Flush to any output. All outputs are registered or slices of registers.

Test Plan:
- Reset then run: hold reset=0 for 2 edges, release, Instruction_i=32'h2008_0005 → PC_o=0x0040_0000, then 0x0040_0004; IF_ID_Instruction=0x2008_0005, IF_ID_PCPlus4=0x0040_0004, IF_ID_Valid=1.
- Load-use stall: Stall=1 for 3 edges at PC=0x0040_0008 → PC_o and IF/ID unchanged for 3 cycles, StallCount=3; advance resumes with PC_o=0x0040_000C one edge after Stall drops.
- Branch flush: Flush=1, BranchTarget=0x0040_0103 → next PC_o=0x0040_0100, IF_ID_Instruction=0, IF_ID_Valid=0, IF_ID_RegisterRs/Rt=0, FlushCount=1.
- Simultaneous Stall=1, Flush=1, BranchTarget=0x0040_0200 → PC_o=0x0040_0200, bubble inserted, FlushCount+1, StallCount unchanged.
- Boundaries:
  - Set the PC to 0xFFFF_FFFC via Flush, then one normal edge → PC_o=0, IF_ID_PCPlus4=0.
  - With CNT_WIDTH=2, hold Stall for 5 edges → StallCount saturates at 3.
- Reset mid-stall: Stall=1 and reset=0 on the same edge → PC_o=RESET_PC, IF_ID_Valid=0, counters 0.
